// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response sequencer driving the combinational ALU, with multi-bit shifts built from single-bit passes
module alu_op_sequencer #(
  parameter int W  = 8,
  parameter int CW = 3
) (
  input  logic         CLK,
  input  logic         Reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic [2:0]   ALUOp,
  output logic [W-1:0] SrcA,
  output logic [W-1:0] SrcB,
  input  logic [W-1:0] Result,
  input  logic         N,
  input  logic         Z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_n,
  output logic         rsp_z,
  output logic         rsp_err,
  output logic         busy
);

  localparam logic [2:0] K_SLL = 3'd3;
  localparam logic [2:0] K_SRL = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state_q;
  logic [2:0]     op_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   res_q;
  logic           n_q;
  logic           z_q;
  logic           err_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            acc_q   <= req_a;
            b_q     <= req_b;
            cnt_q   <= req_b[CW-1:0];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (op_q > K_SRL) begin
            res_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else if (op_q == K_SLL || op_q == K_SRL) begin
            err_q <= 1'b0;
            if (cnt_q == '0) begin
              // Shift by zero never consults the ALU; flags are derived locally.
              res_q   <= acc_q;
              n_q     <= acc_q[W-1];
              z_q     <= (acc_q == '0);
              state_q <= DONE;
            end else begin
              acc_q <= Result;
              cnt_q <= cnt_q - CW'(1);
              if (cnt_q == CW'(1)) begin
                res_q   <= Result;
                n_q     <= N;
                z_q     <= Z;
                state_q <= DONE;
              end
            end
          end else begin
            res_q   <= Result;
            n_q     <= N;
            z_q     <= Z;
            err_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign ALUOp      = op_q;
  assign SrcA       = acc_q;
  assign SrcB       = b_q;
  assign rsp_result = res_q;
  assign rsp_n      = n_q;
  assign rsp_z      = z_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized and directed bench for alu_op_sequencer against a transaction-level model
module tb_alu_op_sequencer;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = '0;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [2:0] ALUOp;
  logic [7:0] SrcA, SrcB, Result;
  logic       N, Z;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_n, rsp_z, rsp_err, busy;

  int tests = 0;
  int fails = 0;
  logic [7:0] last_res;
  logic       last_n, last_z, last_err;
  int         last_lat;

  always #5 CLK = ~CLK;

  alu_op_sequencer #(.W(8), .CW(3)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .ALUOp(ALUOp), .SrcA(SrcA), .SrcB(SrcB),
    .Result(Result), .N(N), .Z(Z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_n(rsp_n), .rsp_z(rsp_z),
    .rsp_err(rsp_err), .busy(busy)
  );

  // Combinational ALU: single-bit shifts, SrcB ignored for shifts.
  always_comb begin
    case (ALUOp)
      3'd0:    Result = SrcA + SrcB;
      3'd1:    Result = SrcA - SrcB;
      3'd2:    Result = SrcA & SrcB;
      3'd3:    Result = SrcA << 1;
      3'd4:    Result = SrcA >> 1;
      default: Result = 8'h00;
    endcase
    N = Result[7];
    Z = (Result == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] shifted(input logic [2:0] op, input logic [7:0] a, input int s);
    logic [7:0] r;
    r = (op == 3'd3) ? (a << s) : (a >> s);
    return r;
  endfunction

  // Whole-operation reference: final result/flags and accept-to-valid latency in edges.
  task automatic ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic n, output logic z,
                        output logic e, output int lat);
    int s;
    s = int'(b[2:0]);
    e = 1'b0;
    lat = 2;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3, 3'd4: begin
        r = shifted(op, a, s);
        if (s > 1) lat = s + 1;
      end
      default: begin r = 8'h00; e = 1'b1; end
    endcase
    n = e ? 1'b0 : r[7];
    z = e ? 1'b0 : (r == 8'h00);
  endtask

  // hold==0: rsp_ready already high when rsp_valid rises; otherwise held low for hold cycles.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [7:0] er;
    logic en, ez, ee;
    int elat, edges, s;
    bit seen;
    ref_op(op, a, b, er, en, ez, ee, elat);
    s = int'(b[2:0]);
    @(negedge CLK);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    rsp_ready = (hold == 0);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    edges = 1;
    seen = 0;
    while (edges < 20) begin
      @(negedge CLK);
      if (rsp_valid) begin seen = 1; break; end
      chk("exec_busy", {busy, req_ready}, 2'b10);
      chk("exec_aluop", ALUOp, op);
      if ((op == 3'd3 || op == 3'd4) && (edges - 1) < s)
        chk("exec_srca", SrcA, shifted(op, a, edges - 1));
      else if (op < 3'd3)
        chk("exec_srcab", {SrcA, SrcB}, {a, b});
      @(posedge CLK);
      edges++;
    end
    chk("rsp_seen", seen, 1'b1);
    chk("latency", edges, elat);
    chk("rsp_fields", {rsp_result, rsp_n, rsp_z, rsp_err}, {er, en, ez, ee});
    last_res = rsp_result; last_n = rsp_n; last_z = rsp_z; last_err = rsp_err; last_lat = edges;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("hold_stable", {rsp_valid, busy, req_ready, rsp_result, rsp_n, rsp_z, rsp_err},
          {1'b1, 1'b1, 1'b0, er, en, ez, ee});
    end
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1 rsp_ready = 1'b0;
    chk("back_idle", {rsp_valid, busy, req_ready}, 3'b001);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {rsp_valid, busy, req_ready, rsp_result, rsp_n, rsp_z, rsp_err},
        {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
    chk("reset_alu_drive", {ALUOp, SrcA, SrcB}, 19'h0);
    Reset_n = 1'b1;

    do_op(3'd0, 8'h80, 8'h7F, 1);
    chk("pin_add", {last_res, last_n, last_z, last_err}, {8'hFF, 1'b1, 1'b0, 1'b0});
    chk("pin_add_lat", last_lat, 2);
    do_op(3'd1, 8'h80, 8'h7F, 0);
    chk("pin_sub", {last_res, last_n, last_z}, {8'h01, 1'b0, 1'b0});
    do_op(3'd2, 8'h80, 8'h7F, 5);
    chk("pin_and", {last_res, last_n, last_z}, {8'h00, 1'b0, 1'b1});
    do_op(3'd3, 8'h81, 8'h03, 1);
    chk("pin_sll3", last_res, 8'h08);
    chk("pin_sll3_lat", last_lat, 4);
    do_op(3'd4, 8'h80, 8'h00, 0);
    chk("pin_srl0", {last_res, last_n, last_z}, {8'h80, 1'b1, 1'b0});
    chk("pin_srl0_lat", last_lat, 2);
    do_op(3'd4, 8'hFF, 8'h0F, 2);
    chk("pin_srl7", last_res, 8'h01);
    do_op(3'd3, 8'hFF, 8'h07, 0);
    chk("pin_sll7", last_res, 8'h80);
    do_op(3'd5, 8'h12, 8'h00, 1);
    chk("pin_illegal", {last_res, last_err}, {8'h00, 1'b1});
    chk("pin_illegal_lat", last_lat, 2);
    do_op(3'd0, 8'h01, 8'h01, 0);
    chk("pin_after_err", {last_res, last_err}, {8'h02, 1'b0});

    for (int t = 0; t < 60; t++)
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    // Reset during the 2nd EXEC cycle of an SLL by 5.
    @(negedge CLK);
    req_valid = 1'b1; req_op = 3'd3; req_a = 8'h01; req_b = 8'h05;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("midop_exec", {busy, SrcA}, {1'b1, 8'h02});
    Reset_n = 1'b0;
    #1;
    chk("midop_reset", {rsp_valid, busy, req_ready, rsp_result, ALUOp, SrcA}, {1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h00});
    @(negedge CLK);
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("no_rsp_after_reset", {rsp_valid, busy, req_ready}, 3'b001);
    end
    do_op(3'd1, 8'h00, 8'h01, 1);
    chk("pin_sub_wrap", {last_res, last_n}, {8'hFF, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Hardware initiator for the combinational ALU: accepts an operation request over a valid/ready handshake, drives ALUOp/SrcA/SrcB, and captures Result/N/Z.
- Returns the result over a valid/ready response channel.
- Multi-bit shifts (shift count in req_b[2:0]) are built by iterating the ALU's single-bit kSLL/kSRL, one ALU pass per clock.
- Sits between the decode/control logic and the ALU in the datapath.

Parameters:
- W, 8, datapath width; matches ALU SrcA/SrcB/Result.
- CW, 3, shift-count width; the count is taken from req_b[CW-1:0].

Ports:
- CLK  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  operation, ALUOp_mne encoding: kADD=0, kSUB=1, kAND=2, kSLL=3, kSRL=4; 5..7 illegal.
- req_a  in  W  operand A.
- req_b  in  W  operand B; for shifts, [CW-1:0] is the shift count.
- ALUOp  out  3  to ALU.
- SrcA  out  W  to ALU.
- SrcB  out  W  to ALU.
- Result  in  W  from ALU.
- N  in  1  ALU negative flag.
- Z  in  1  ALU zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  W  final result.
- rsp_n  out  1  final negative flag.
- rsp_z  out  1  final zero flag.
- rsp_err  out  1  illegal opcode.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock domain (CLK). Reset_n is asynchronous, active-low.
- Reset values: state=IDLE; op_q=0, acc=0, b_q=0, cnt=0; rsp_result=0, rsp_n=0, rsp_z=0, rsp_err=0; rsp_valid=0, busy=0.
- ALU drive: ALUOp=op_q, SrcA=acc, SrcB=b_q, all registered. The ALU combinationally shifts SrcA by one bit for kSLL/kSRL and ignores SrcB in that case.
- State machine: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch op_q=req_op, acc=req_a, b_q=req_b, cnt=req_b[CW-1:0]; go to EXEC.
- EXEC (req_ready=0):
  - Illegal op (5..7): rsp_err=1, rsp_result=0, rsp_n=0, rsp_z=0; go to DONE. The ALU output is ignored.
  - kADD/kSUB/kAND: capture Result, N, Z into rsp_*, rsp_err=0; go to DONE.
  - Shift with cnt==0: rsp_result=acc, rsp_n=acc[W-1], rsp_z=(acc==0); go to DONE. The ALU output is ignored.
  - Shift with cnt>=1: acc<=Result, cnt<=cnt-1. If cnt==1, also capture Result, N, Z into rsp_* and go to DONE; otherwise stay in EXEC.
- DONE:
  - rsp_valid=1; rsp_* held stable while rsp_ready=0.
  - On rsp_ready: go to IDLE.
  - No request is accepted in DONE (req_ready=0); there is no overlap between response and next request.
- Latency, measured from the accept edge to rsp_valid high:
  - Arithmetic/logic, illegal op, and shift by 0: 2 edges.
  - Shift by s (1..7): s+1 edges.
  - Best-case throughput: one operation per 3 cycles.
- Width rules: ADD/SUB wrap modulo 2^W. Flags come from the ALU except in the local cases above (illegal op, shift by 0).
- Bounds: req_b bits above CW-1 are ignored for shifts. Shift by 7 of 0xFF yields 0x80 (SLL) or 0x01 (SRL).
- Simultaneous events: rsp_ready may be high on the cycle rsp_valid rises; the handshake completes that edge.
- Reset mid-operation: asynchronous return to IDLE with all registers at reset values. Any in-flight operation is discarded and no response is produced.

Test Plan:
- Reset, then req kADD a=0x80 b=0x7F -> rsp_valid 2 edges after accept; result=0xFF, n=1, z=0, err=0; then kSUB same operands -> 0x01, n=0, z=0.
- kAND a=0x80 b=0x7F -> result=0x00, z=1, n=0; with rsp_ready low for 5 cycles -> rsp_* stable, req_ready=0, busy=1 throughout.
- kSLL a=0x81 b=0x03 -> ALUOp=3 for exactly 3 EXEC cycles with SrcA 0x81, 0x02, 0x04; result=0x08, rsp_valid 4 edges after accept.
- kSRL a=0x80 b=0x00 -> result=0x80, n=1, z=0, latency 2; kSRL a=0xFF b=0x0F (count 7) -> 0x01.
- req_op=5, a=0x12 -> rsp_err=1, result=0x00, latency 2; the next legal kADD 0x01+0x01 -> 0x02, err=0.
- Assert Reset_n low during the 2nd EXEC cycle of kSLL by 5 -> state IDLE, rsp_valid=0, req_ready=1 immediately; no response is issued after reset release.
